wptr_full_ctrl: RTL
===================

// Module: wptr_full_ctrl
// PURPOSE
//  Write-domain pointer and full-flag generator for the async FIFO; drives waddr/wclken/wfull of the dual-port memory.
//  Syncs read-domain Gray pointer into wclk, keeps binary+Gray write pointers, flags full, overflow and a fill level.
//  Exports its Gray write pointer to the read-side controller.
// PARAMETERS
//  ADDRSIZE     4            memory address bits; depth = 2**ADDRSIZE; legal range >= 2
//  SYNC_STAGES  2            flops in rptr->wclk synchronizer; legal range >= 2
//  AFULL_THRESH (1<<ADDRSIZE)-2  level at/above which wafull asserts (optional feature only)
// PORTS
//  wclk    in   1           write clock
//  wrst_n  in   1           asynchronous active-low reset
//  winc    in   1           write request this cycle
//  rptr    in   ADDRSIZE+1  Gray read pointer from read domain (async to wclk)
//  wptr    out  ADDRSIZE+1  registered Gray write pointer, to read domain
//  waddr   out  ADDRSIZE    memory write address (= wbin[ADDRSIZE-1:0])
//  wclken  out  1           memory write enable = winc & ~wfull (combinational)
//  wfull   out  1           registered full flag
//  wlevel  out  ADDRSIZE+1  registered pessimistic fill count, 0..DEPTH
//  wovf    out  1           sticky overflow error
//  wafull  out  1           registered almost-full (see CONFIGURATION)
// BEHAVIOUR
//  Reset (wrst_n low, async): wbin=0, wptr=0, waddr=0, wfull=0, wlevel=0, wovf=0, wafull=0, sync flops=0.
//   Deassertion takes effect on the next wclk edge; reset mid-write discards the write and restarts pointers at 0.
//  Push: push = winc & ~wfull; wbinnext = wbin + push (mod 2**(ADDRSIZE+1)); wgraynext = wbinnext ^ (wbinnext>>1).
//   wbin<=wbinnext, wptr<=wgraynext each edge; waddr advances one edge after an accepted write.
//  Sync: wq2_rptr = rptr after SYNC_STAGES wclk flops; no other logic on the crossing path.
//  Full: wfull <= (wgraynext == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]}), A=ADDRSIZE.
//   Asserts on the edge completing the DEPTH-th outstanding write (same edge that registers that write).
//   Deasserts SYNC_STAGES+1 edges after rptr moves (pessimistic, never optimistic).
//  Level: wlevel <= wbinnext - gray2bin(wq2_rptr), ADDRSIZE+1-bit modular subtract; equals DEPTH when full.
//  Overflow: winc & wfull -> write dropped (wclken=0, pointers hold), wovf<=1; wovf clears only on reset.
//  Simultaneous winc and rptr change at full: write dropped this cycle; accepted once wfull has cleared.
//  Wrap: pointers roll DEPTH*2-1 -> 0; MSB of wptr toggles each lap; waddr wraps DEPTH-1 -> 0 without bubble.
// CONFIGURATION
//  Macro WPTR_FULL_AFULL_EN:
//   defined   -> wafull <= (wlevel_next >= AFULL_THRESH), reset 0, deasserts with same sync latency as wfull.
//   undefined -> wafull tied 0; no threshold compare logic; AFULL_THRESH ignored.
// STRUCTURE
//  Package async_fifo_pkg: bin2gray/gray2bin functions (width-generic via max-width logic type),
//   localparam helper for DEPTH, typedef for pointer-width vectors shared with read-side controller.
//  Sub-module sync_r2w: SYNC_STAGES-deep flop chain, wclk/wrst_n, reset 0; only instance in this block.
// TESTING (ADDRSIZE=4, DEPTH=16, SYNC_STAGES=2)
//  Fill: rptr=0, winc=1 for 16 cycles -> waddr 0..15, wfull=1 after 16th edge, wptr=5'b11000, wlevel=16.
//  Overflow: 17th winc while full -> wclken=0, waddr stays 0, wptr unchanged, wovf=1 and stays 1.
//  Release: full, drive rptr=5'b00001 -> wfull=0 on 3rd wclk edge, wlevel=15; next winc accepted.
//  Wrap: 40 writes, rptr tracking 2 behind -> waddr wraps 15->0 twice, wptr MSB toggles, wfull never set.
//  Reset mid-op: after 5 writes pull wrst_n low asynchronously -> wptr=0, waddr=0, wfull=0, wlevel=0 before next edge.
//  Almost-full: AFULL_THRESH=14, macro on -> wafull=1 after 14th write; macro off -> wafull stays 0.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Async FIFO shared types and Gray-code helpers.
// Used by both write-side and read-side pointer controllers.
package async_fifo_pkg;

  localparam int unsigned PTR_MAXW = 32;

  // Callers zero-extend pointers into ptr_t and size-cast the result back.
  typedef logic [PTR_MAXW-1:0] ptr_t;

  function automatic int unsigned fifo_depth(input int unsigned asize);
    return 32'd1 << asize;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAXW-1] = g[PTR_MAXW-1];
    for (int i = PTR_MAXW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_r2w.sv
// Read-pointer synchronizer into the write clock domain.
// Plain flop chain; nothing else sits on the crossing path.
module sync_r2w #(
  parameter int unsigned W      = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic         wclk,
  input  logic         wrst_n,
  input  logic [W-1:0] rptr,
  output logic [W-1:0] wq2_rptr
);

  logic [STAGES-1:0][W-1:0] sync_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], rptr};
    end
  end

  assign wq2_rptr = sync_q[STAGES-1];

endmodule

// File: rtl/wptr_full_ctrl.sv
// Async FIFO write-side pointer, full, level and overflow control.
// Optional almost-full output: define WPTR_FULL_AFULL_EN.
module wptr_full_ctrl
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE     = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned AFULL_THRESH = (1 << ADDRSIZE) - 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wclken,
  output logic                wfull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf,
  output logic                wafull
);

  localparam int unsigned A  = ADDRSIZE;
  localparam int unsigned PW = ADDRSIZE + 1;

  logic [PW-1:0] wq2_rptr;
  logic [PW-1:0] rbin;
  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic [PW-1:0] full_cmp;
  logic          wfull_q, wfull_d;
  logic          wovf_q, wovf_d;
  logic          push;

  sync_r2w #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync_r2w (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .rptr     (rptr),
    .wq2_rptr (wq2_rptr)
  );

  assign push     = winc & ~wfull_q;
  assign rbin     = PW'(gray2bin(ptr_t'(wq2_rptr)));
  // Full when write is a lap ahead: top two Gray bits inverted.
  assign full_cmp = {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]};

  always_comb begin
    wbin_d   = wbin_q + PW'(push);
    wgray_d  = PW'(bin2gray(ptr_t'(wbin_d)));
    wfull_d  = (wgray_d == full_cmp);
    wlevel_d = wbin_d - rbin;
    wovf_d   = wovf_q | (winc & wfull_q);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wfull_q  <= 1'b0;
      wlevel_q <= '0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wfull_q  <= wfull_d;
      wlevel_q <= wlevel_d;
      wovf_q   <= wovf_d;
    end
  end

`ifdef WPTR_FULL_AFULL_EN
  logic wafull_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wafull_q <= 1'b0;
    end else begin
      wafull_q <= ({1'b0, wlevel_d} >= (PW+1)'(AFULL_THRESH));
    end
  end

  assign wafull = wafull_q;
`else
  assign wafull = 1'b0;
`endif

  assign wptr   = wgray_q;
  assign waddr  = wbin_q[A-1:0];
  assign wclken = push;
  assign wfull  = wfull_q;
  assign wlevel = wlevel_q;
  assign wovf   = wovf_q;

endmodule
